// File: rtl/sal_bank_fsm_pkg.sv
// sal_bank_fsm shared types: request field types, bank state enum,
// default DRAM timing constants (SAL_DDR_PARAMS defaults).
package sal_bank_fsm_pkg;

  typedef logic [15:0] dram_ra_t;
  typedef logic [9:0]  dram_ca_t;
  typedef logic [3:0]  axi_id_t;
  typedef logic [7:0]  axi_len_t;
  typedef logic [7:0]  seq_num_t;

  typedef enum logic [2:0] {
    CLOSED,
    ACTIVATING,
    OPEN,
    PRECHARGING,
    REFRESHING
  } bank_st_e;

  localparam int T_RCD_DEF = 4;
  localparam int T_RAS_DEF = 12;
  localparam int T_RP_DEF  = 4;
  localparam int T_WR_DEF  = 8;
  localparam int T_RTP_DEF = 3;
  localparam int T_RFC_DEF = 52;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sal_bank_fsm_timer.sv
// sal_bk_timer: loadable saturating down-counter, zero = constraint met.
// Ports: clk, rst_n, load (reload with T-1), zero (count is 0).
module sal_bk_timer #(
  parameter int CNT_W = 8,
  parameter int T     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  localparam logic [CNT_W-1:0] LD  = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LD;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_fsm.sv
// sal_bank_fsm: per-bank ACT/RD/WR/PRE/REF generator with bank timers.
// Ports: request queue handshake + fields, ref_pend/ref_done,
// *_req/*_gnt scheduler pairs, ra/ca/id/len/seq_num of held request.
// SAL_BK_AUTO_PRE_EN: closed-page policy (precharge once idle).
module sal_bank_fsm
  import sal_bank_fsm_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_RP  = T_RP_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int T_RTP = T_RTP_DEF,
  parameter int T_RFC = T_RFC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic     req_wr,
  input  dram_ra_t req_ra,
  input  dram_ca_t req_ca,
  input  axi_id_t  req_id,
  input  axi_len_t req_len,
  input  seq_num_t req_seq_num,
  input  logic     ref_pend,
  output logic     ref_done,
  output logic     act_req,
  output logic     rd_req,
  output logic     wr_req,
  output logic     pre_req,
  output logic     ref_req,
  input  logic     act_gnt,
  input  logic     rd_gnt,
  input  logic     wr_gnt,
  input  logic     pre_gnt,
  input  logic     ref_gnt,
  output dram_ra_t ra,
  output dram_ca_t ca,
  output axi_id_t  id,
  output axi_len_t len,
  output seq_num_t seq_num
);

  bank_st_e state;
  bank_st_e st_eff;
  dram_ra_t open_row;

  logic held;
  logic h_wr;

  logic trcd_z, tras_z, trp_z;
  logic twr_z, trtp_z, trfc_z;

  logic act_g, rd_g, wr_g, pre_g, ref_g;
  logic idle, is_open, hit;
  logic time_ok, pre_want;

  // A timed-out transient state behaves as its successor in the same
  // cycle, so dependent requests rise exactly T cycles after a grant.
  always_comb begin
    st_eff = state;
    unique case (1'b1)
      state == ACTIVATING && trcd_z: st_eff = OPEN;
      state == PRECHARGING && trp_z: st_eff = CLOSED;
      state == REFRESHING && trfc_z: st_eff = CLOSED;
      default: ;
    endcase
  end

  assign idle    = (st_eff == CLOSED);
  assign is_open = (st_eff == OPEN);
  assign hit     = held && (ra == open_row);
  assign time_ok = tras_z && twr_z && trtp_z;

`ifdef SAL_BK_AUTO_PRE_EN
  assign pre_want = held ? !hit : 1'b1;
`else
  assign pre_want = held ? !hit : ref_pend;
`endif

  // rst_n gates the outputs that depend on the ref_pend input directly.
  assign ref_req = rst_n && idle && ref_pend && trp_z;
  assign act_req = idle && !ref_pend && held
                   && trp_z && trfc_z;
  assign rd_req  = is_open && hit && !h_wr;
  assign wr_req  = is_open && hit && h_wr;
  assign pre_req = is_open && pre_want && time_ok;

  assign req_ready = rst_n && !held && !ref_pend;

  assign act_g = act_req && act_gnt;
  assign rd_g  = rd_req && rd_gnt;
  assign wr_g  = wr_req && wr_gnt;
  assign pre_g = pre_req && pre_gnt;
  assign ref_g = ref_req && ref_gnt;

  assign ref_done = ref_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLOSED;
      open_row <= '0;
    end else begin
      unique case (st_eff)
        CLOSED: begin
          if (ref_g) begin
            state <= REFRESHING;
          end else if (act_g) begin
            state    <= ACTIVATING;
            open_row <= ra;
          end else begin
            state <= CLOSED;
          end
        end
        OPEN:    state <= pre_g ? PRECHARGING : OPEN;
        default: state <= st_eff;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held    <= 1'b0;
      h_wr    <= 1'b0;
      ra      <= '0;
      ca      <= '0;
      id      <= '0;
      len     <= '0;
      seq_num <= '0;
    end else if (req_valid && req_ready) begin
      held    <= 1'b1;
      h_wr    <= req_wr;
      ra      <= req_ra;
      ca      <= req_ca;
      id      <= req_id;
      len     <= req_len;
      seq_num <= req_seq_num;
    end else if (rd_g || wr_g) begin
      held <= 1'b0;
    end
  end

  sal_bk_timer #(.CNT_W(CNT_W), .T(T_RCD)) u_trcd (
    .clk(clk), .rst_n(rst_n), .load(act_g), .zero(trcd_z));
  sal_bk_timer #(.CNT_W(CNT_W), .T(T_RAS)) u_tras (
    .clk(clk), .rst_n(rst_n), .load(act_g), .zero(tras_z));
  sal_bk_timer #(.CNT_W(CNT_W), .T(T_RP)) u_trp (
    .clk(clk), .rst_n(rst_n), .load(pre_g), .zero(trp_z));
  sal_bk_timer #(.CNT_W(CNT_W), .T(T_WR)) u_twr (
    .clk(clk), .rst_n(rst_n), .load(wr_g), .zero(twr_z));
  sal_bk_timer #(.CNT_W(CNT_W), .T(T_RTP)) u_trtp (
    .clk(clk), .rst_n(rst_n), .load(rd_g), .zero(trtp_z));
  sal_bk_timer #(.CNT_W(CNT_W), .T(T_RFC)) u_trfc (
    .clk(clk), .rst_n(rst_n), .load(ref_g), .zero(trfc_z));

`ifndef SYNTHESIS
  gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}));
`endif

endmodule

// File: tb/tb_sal_bank_fsm.sv
// tb_sal_bank_fsm: directed timeline plus random traffic, checked
// every cycle against a timestamp-based bank model.
module tb_sal_bank_fsm;
  import sal_bank_fsm_pkg::*;

`ifdef SAL_BK_AUTO_PRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int RCD = 4, RAS = 12, RP = 4;
  localparam int WR = 8, RTP = 3, RFC = 52;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_wr;
  dram_ra_t req_ra;
  dram_ca_t req_ca;
  axi_id_t  req_id;
  axi_len_t req_len;
  seq_num_t req_seq_num;
  logic ref_pend, ref_done;
  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  dram_ra_t ra;
  dram_ca_t ca;
  axi_id_t  id;
  axi_len_t len;
  seq_num_t seq_num;

  always #5 clk = ~clk;

  sal_bank_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_ra(req_ra), .req_ca(req_ca),
    .req_id(req_id), .req_len(req_len),
    .req_seq_num(req_seq_num),
    .ref_pend(ref_pend), .ref_done(ref_done),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
    .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .ra(ra), .ca(ca), .id(id), .len(len), .seq_num(seq_num)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  // model: timestamps of last grants, open row, held request
  int t_act, t_pre, t_rd, t_wr, t_ref;
  bit m_open, m_held, m_wr, ref_clr;
  dram_ra_t m_row, m_ra;
  dram_ca_t m_ca;
  axi_id_t  m_id;
  axi_len_t m_len;
  seq_num_t m_seq;
  bit e_act, e_rd, e_wr, e_pre, e_ref, e_ready, e_done;

  dram_ra_t rows [3] = '{16'h12, 16'h34, 16'h56};

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    t_act = -1000; t_pre = -1000; t_rd = -1000;
    t_wr = -1000; t_ref = -1000;
    m_open = 0; m_held = 0; m_wr = 0; ref_clr = 0;
    m_row = '0;
  endfunction

  function automatic void eval();
    bit idle, usable, hit, tok;
    idle   = !m_open && cyc >= t_pre + RP
             && cyc >= t_ref + RFC;
    usable = m_open && cyc >= t_act + RCD;
    hit    = m_held && m_ra == m_row;
    tok    = cyc >= t_act + RAS && cyc >= t_wr + WR
             && cyc >= t_rd + RTP;
    e_ref   = idle && ref_pend;
    e_act   = idle && !ref_pend && m_held;
    e_rd    = usable && hit && !m_wr;
    e_wr    = usable && hit && m_wr;
    e_pre   = usable && tok && ((m_held && !hit)
              || (!m_held && (ref_pend || AUTO)));
    e_ready = !m_held && !ref_pend;
    e_done  = e_ref && ref_gnt;
  endfunction

  task automatic half();
    eval();
    @(negedge clk);
    vectors++;
    chk("act_req", act_req, e_act);
    chk("rd_req", rd_req, e_rd);
    chk("wr_req", wr_req, e_wr);
    chk("pre_req", pre_req, e_pre);
    chk("ref_req", ref_req, e_ref);
    chk("req_ready", req_ready, e_ready);
    chk("ref_done", ref_done, e_done);
    if (e_act) chk("act_ra", ra, m_ra);
    if (e_rd || e_wr) begin
      chk("col_ra", ra, m_ra);
      chk("col_ca", ca, m_ca);
      chk("col_id", id, m_id);
      chk("col_len", len, m_len);
      chk("col_seq", seq_num, m_seq);
    end
  endtask

  task automatic fin();
    if (req_valid && e_ready) begin
      m_held = 1; m_wr = req_wr; m_ra = req_ra;
      m_ca = req_ca; m_id = req_id; m_len = req_len;
      m_seq = req_seq_num;
    end
    if (rd_gnt && e_rd) begin m_held = 0; t_rd = cyc; end
    if (wr_gnt && e_wr) begin m_held = 0; t_wr = cyc; end
    if (act_gnt && e_act) begin
      m_open = 1; m_row = m_ra; t_act = cyc;
    end
    if (pre_gnt && e_pre) begin m_open = 0; t_pre = cyc; end
    if (ref_gnt && e_ref) begin t_ref = cyc; ref_clr = 1; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_gnt();
    act_gnt = 0; rd_gnt = 0; wr_gnt = 0;
    pre_gnt = 0; ref_gnt = 0;
  endtask

  task automatic rand_fields();
    req_ra = rows[$urandom_range(2)];
    req_wr = 1'($urandom_range(1));
    req_ca = dram_ca_t'($urandom);
    req_id = axi_id_t'($urandom);
    req_len = axi_len_t'($urandom);
    req_seq_num = seq_num_t'($urandom);
  endtask

  task automatic rand_cycle();
    clr_gnt();
    rand_fields();
    req_valid = ($urandom_range(2) == 0);
    if (ref_clr) begin
      ref_pend = 0; ref_clr = 0;
    end else if (!ref_pend && $urandom_range(59) == 0) begin
      ref_pend = 1;
    end
    eval();
    if ($urandom_range(1) == 1) begin
      if (e_act) act_gnt = 1;
      else if (e_rd) rd_gnt = 1;
      else if (e_wr) wr_gnt = 1;
      else if (e_pre) pre_gnt = 1;
      else if (e_ref) ref_gnt = 1;
    end else if ($urandom_range(7) == 0) begin
      case ($urandom_range(4))
        0: act_gnt = 1;
        1: rd_gnt = 1;
        2: wr_gnt = 1;
        3: pre_gnt = 1;
        default: ref_gnt = 1;
      endcase
    end
    half();
    fin();
  endtask

  initial begin
    bit found;
    rst_n = 0; req_valid = 0; ref_pend = 0;
    req_wr = 0; req_ra = '0; req_ca = '0; req_id = '0;
    req_len = '0; req_seq_num = '0;
    clr_gnt();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0;

    // directed timeline with hand-computed cycle numbers
    for (int c = 0; c < 126; c++) begin
      req_valid = (c == 8) || (c == 15) || (c == 17)
                  || (c == 31) || (c == 59);
      req_wr = (c == 17);
      req_ra = (c == 17) ? 16'h34 :
               (c == 31) ? 16'h56 : 16'h12;
      req_ca = dram_ca_t'(c); req_id = axi_id_t'(c);
      req_len = axi_len_t'(c); req_seq_num = seq_num_t'(c);
      act_gnt = (c == 10) || (c == 26) || (c == 42)
                || (c == 110);
      rd_gnt  = (c == 14) || (c == 16) || (c == 48)
                || (c == 114);
      wr_gnt  = (c == 30);
      pre_gnt = (c == 22) || (c == 38) || (c == 54);
      ref_gnt = (c == 58);
      ref_pend = (c >= 47) && (c <= 58);
      half();
      if (c == 0) begin
        chk("t0_ready", req_ready, 1);
        chk("t0_act", act_req, 0);
      end
      if (c == 9) begin
        chk("t9_act", act_req, 1);
        chk("t9_ra", ra, 32'h12);
      end
      if (c == 13) chk("t13_rd", rd_req, 0);
      if (c == 14) chk("t14_rd", rd_req, 1);
      if (c == 16) begin
        chk("t16_rd", rd_req, 1);
        chk("t16_act", act_req, 0);
        chk("t16_pre", pre_req, 0);
      end
      if (c == 21) chk("t21_pre", pre_req, 0);
      if (c == 22) chk("t22_pre", pre_req, 1);
      if (c == 25) chk("t25_act", act_req, 0);
      if (c == 26) begin
        chk("t26_act", act_req, 1);
        chk("t26_ra", ra, 32'h34);
      end
      if (c == 30) chk("t30_wr", wr_req, 1);
      if (c == 37) chk("t37_pre", pre_req, 0);
      if (c == 38) chk("t38_pre", pre_req, 1);
      if (c == 47) begin
        chk("t47_rd", rd_req, 1);
        chk("t47_ready", req_ready, 0);
      end
      if (c == 53) chk("t53_pre", pre_req, 0);
      if (c == 54) chk("t54_pre", pre_req, 1);
      if (c == 58) begin
        chk("t58_ref", ref_req, 1);
        chk("t58_done", ref_done, 1);
      end
      if (c == 109) chk("t109_act", act_req, 0);
      if (c == 110) chk("t110_act", act_req, 1);
      if (c == 122) chk("t122_autopre", pre_req, AUTO);
      fin();
    end
    clr_gnt();
    req_valid = 0;
    ref_clr = 0;

    for (int i = 0; i < 4000; i++) rand_cycle();

    // reach ACTIVATING, then reset mid-operation
    clr_gnt();
    ref_pend = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      clr_gnt();
      rand_fields();
      req_valid = 1;
      eval();
      if (e_act) begin act_gnt = 1; found = 1; end
      else if (e_rd) rd_gnt = 1;
      else if (e_wr) wr_gnt = 1;
      else if (e_pre) pre_gnt = 1;
      else if (e_ref) ref_gnt = 1;
      half();
      fin();
    end
    chk("rst_setup", found, 1);
    clr_gnt();
    req_valid = 0;
    rst_n = 0;
    @(negedge clk);
    chk("rst_act", act_req, 0);
    chk("rst_rd", rd_req, 0);
    chk("rst_wr", wr_req, 0);
    chk("rst_pre", pre_req, 0);
    chk("rst_ref", ref_req, 0);
    chk("rst_done", ref_done, 0);
    chk("rst_ra", ra, 0);
    chk("rst_ca", ca, 0);
    chk("rst_id", id, 0);
    chk("rst_len", len, 0);
    chk("rst_seq", seq_num, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    cyc = 0;
    half();
    chk("post_rst_ready", req_ready, 1);
    fin();

    for (int i = 0; i < 600; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
